// File: rtl/jk_cmd_sequencer.sv
// Command sequencer that drives a downstream JK flip-flop from a small command FIFO,
// models the expected Q and counts mismatches against the observed Q.
module jk_cmd_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_jk,
    input  logic [3:0] cmd_len,
    output logic       cmd_ready,
    input  logic       flush,
    output logic       J,
    output logic       K,
    input  logic       Q_obs,
    output logic       exp_q,
    output logic       busy,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [3:0]    rem_q, rem_d;
    logic          j_q, k_q, j_d, k_d;
    logic          pop, push, empty, full;
    logic [EW-1:0] head;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign push      = cmd_valid && !full && !flush;
    assign head      = mem[rd_ptr];
    assign cmd_ready = !full;
    assign busy      = (state_q == DRIVE) || !empty;
    assign J         = j_q;
    assign K         = k_q;

    // State register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!empty) state_d = DRIVE;
                DRIVE:   if (rem_q == 4'd0 && empty) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output / datapath next values; a finished command pops the next one with no bubble
    always_comb begin
        pop   = 1'b0;
        j_d   = j_q;
        k_d   = k_q;
        rem_d = rem_q;
        if (flush) begin
            j_d   = 1'b0;
            k_d   = 1'b0;
            rem_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    j_d = 1'b0;
                    k_d = 1'b0;
                    if (!empty) begin
                        pop   = 1'b1;
                        j_d   = head[5];
                        k_d   = head[4];
                        rem_d = head[3:0];
                    end
                end
                DRIVE: begin
                    if (rem_q != 4'd0) begin
                        rem_d = rem_q - 4'd1;
                    end else if (!empty) begin
                        pop   = 1'b1;
                        j_d   = head[5];
                        k_d   = head[4];
                        rem_d = head[3:0];
                    end else begin
                        j_d = 1'b0;
                        k_d = 1'b0;
                    end
                end
                default: begin
                    j_d = 1'b0;
                    k_d = 1'b0;
                end
            endcase
        end
    end

    // Drive registers and FIFO pointers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            j_q    <= 1'b0;
            k_q    <= 1'b0;
            rem_q  <= 4'd0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            j_q   <= j_d;
            k_q   <= k_d;
            rem_q <= rem_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // FIFO storage needs no reset; validity is tracked by count
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= {cmd_jk, cmd_len};
    end

    // Expected-Q model (uses pre-edge J,K even on flush) and mismatch tracking
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            exp_q   <= 1'b0;
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            case ({j_q, k_q})
                2'b01:   exp_q <= 1'b0;
                2'b10:   exp_q <= 1'b1;
                2'b11:   exp_q <= ~exp_q;
                default: exp_q <= exp_q;
            endcase
            if (!flush && (Q_obs != exp_q)) begin
                err <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
